// File: rtl/mpi_wb_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mpi_wb_mc                                                       |
// | Brief    : Multi-channel Wishbone message-passing endpoint with per-channel|
// |            TX/RX flit FIFOs, packet framing, status and interrupt enables. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mpi_wb_mc #(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int SIZE           = 16,
  parameter int N              = 1,
  parameter bit TX_STORE_FWD   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [N*NOC_FLIT_WIDTH-1:0] noc_out_flit,
  output logic [N-1:0]                noc_out_last,
  output logic [N-1:0]                noc_out_valid,
  input  logic [N-1:0]                noc_out_ready,
  input  logic [N*NOC_FLIT_WIDTH-1:0] noc_in_flit,
  input  logic [N-1:0]                noc_in_last,
  input  logic [N-1:0]                noc_in_valid,
  output logic [N-1:0]                noc_in_ready,
  input  logic [31:0]                 wb_adr_i,
  input  logic                        wb_we_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic [31:0]                 wb_dat_i,
  output logic [31:0]                 wb_dat_o,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic                        irq
);

  localparam int c_aw = $clog2(SIZE);
  localparam int c_pw = c_aw + 1;
  localparam int c_fw = NOC_FLIT_WIDTH;
  localparam logic [c_pw-1:0] c_one = {{c_aw{1'b0}}, 1'b1};

  localparam logic [3:0] c_reg_data   = 4'h0;
  localparam logic [3:0] c_reg_last   = 4'h1;
  localparam logic [3:0] c_reg_status = 4'h2;
  localparam logic [3:0] c_reg_irqen  = 4'h3;

  logic [2:0]      w_ch;
  logic [3:0]      w_reg;
  logic            w_req;
  logic            w_ch_ok;
  logic [7:0]      w_tx_full_v;
  logic [7:0]      w_rx_empty_v;
  logic [7:0]      w_rx_avail_v;
  logic [31:0]     w_status [8];
  logic [c_fw-1:0] w_rx_head [8];
  logic [7:0]      w_tx_push;
  logic [7:0]      w_rx_pop;
  logic [7:0]      w_ovf_set;
  logic [7:0]      w_ovf_clr;
  logic [7:0]      w_ien_we;
  logic            w_push_last;
  logic            w_is_ack;
  logic            w_is_err;
  logic [31:0]     w_rd_data;
  logic            w_unused;

  logic            r_ack;
  logic            r_err;
  logic [31:0]     r_dat;
  logic [7:0]      r_irq_en;
  logic            r_irq;
  logic            r_rx_en;

  assign w_ch    = wb_adr_i[10:8];
  assign w_reg   = wb_adr_i[5:2];
  assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_ch_ok = (int'(w_ch) < N);

  // Request decode: all FIFO and register side effects happen on this edge.
  always_comb begin
    w_is_ack    = 1'b0;
    w_is_err    = 1'b0;
    w_rd_data   = '0;
    w_tx_push   = '0;
    w_push_last = 1'b0;
    w_rx_pop    = '0;
    w_ovf_set   = '0;
    w_ovf_clr   = '0;
    w_ien_we    = '0;
    if (w_req) begin
      if (!w_ch_ok) begin
        w_is_err = 1'b1;
      end else begin
        case (w_reg)
          c_reg_data, c_reg_last: begin
            if (wb_we_i) begin
              if (w_tx_full_v[w_ch]) begin
                w_is_err         = 1'b1;
                w_ovf_set[w_ch]  = 1'b1;
              end else begin
                w_is_ack         = 1'b1;
                w_tx_push[w_ch]  = 1'b1;
                w_push_last      = (w_reg == c_reg_last);
              end
            end else if (w_reg == c_reg_last || w_rx_empty_v[w_ch]) begin
              w_is_err = 1'b1;
            end else begin
              w_is_ack         = 1'b1;
              w_rx_pop[w_ch]   = 1'b1;
              w_rd_data        = 32'(w_rx_head[w_ch]);
            end
          end
          c_reg_status: begin
            w_is_ack = 1'b1;
            if (wb_we_i) begin
              w_ovf_clr[w_ch] = wb_dat_i[3];
            end else begin
              w_rd_data = w_status[w_ch];
            end
          end
          c_reg_irqen: begin
            w_is_ack = 1'b1;
            if (wb_we_i) begin
              w_ien_we[w_ch] = 1'b1;
            end else begin
              w_rd_data = {31'd0, r_irq_en[w_ch]};
            end
          end
          default: w_is_err = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= '0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
      r_rx_en  <= 1'b0;
    end else begin
      r_ack    <= w_is_ack;
      r_err    <= w_is_err;
      r_dat    <= w_is_ack ? w_rd_data : 32'd0;
      r_irq_en <= (r_irq_en & ~w_ien_we) | (w_ien_we & {8{wb_dat_i[0]}});
      r_irq    <= |(r_irq_en & w_rx_avail_v);
      r_rx_en  <= 1'b1;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_dat_o = r_dat;
  assign irq      = r_irq;

  for (genvar g = 0; g < 8; g++) begin : g_chan
    if (g < N) begin : g_act
      logic [c_fw:0]   r_tx_mem [SIZE];
      logic [c_pw-1:0] r_tx_wp;
      logic [c_pw-1:0] r_tx_rp;
      logic [c_pw-1:0] r_tx_pkts;
      logic            r_tx_busy;
      logic            r_ovf;
      logic [c_fw:0]   r_rx_mem [SIZE];
      logic [c_pw-1:0] r_rx_wp;
      logic [c_pw-1:0] r_rx_rp;
      logic [c_pw-1:0] r_rx_pkts;

      logic [c_fw:0]   w_tx_head;
      logic [c_pw-1:0] w_tx_level;
      logic            w_tx_empty;
      logic            w_tx_full;
      logic            w_tx_valid;
      logic            w_tx_go;
      logic            w_tx_inc;
      logic            w_tx_dec;
      logic [c_fw:0]   w_rx_top;
      logic            w_rx_empty;
      logic            w_rx_full;
      logic            w_rx_rdy;
      logic            w_rx_acc;
      logic            w_rx_inc;
      logic            w_rx_dec;

      // ---------------- TX ----------------
      assign w_tx_head  = r_tx_mem[r_tx_rp[c_aw-1:0]];
      assign w_tx_level = r_tx_wp - r_tx_rp;
      assign w_tx_empty = (r_tx_wp == r_tx_rp);
      assign w_tx_full  = (r_tx_wp[c_aw] != r_tx_rp[c_aw]) &&
                          (r_tx_wp[c_aw-1:0] == r_tx_rp[c_aw-1:0]);
      // A queued complete packet, or one already streaming, may be released.
      assign w_tx_valid = !w_tx_empty &&
                          (!TX_STORE_FWD || (r_tx_pkts != '0) || r_tx_busy);
      assign w_tx_go    = w_tx_valid & noc_out_ready[g];
      assign w_tx_inc   = w_tx_push[g] & w_push_last;
      assign w_tx_dec   = w_tx_go & w_tx_head[c_fw];

      always_ff @(posedge clk) begin
        if (w_tx_push[g]) begin
          r_tx_mem[r_tx_wp[c_aw-1:0]] <= {w_push_last, wb_dat_i[c_fw-1:0]};
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_tx_wp   <= '0;
          r_tx_rp   <= '0;
          r_tx_pkts <= '0;
          r_tx_busy <= 1'b0;
          r_ovf     <= 1'b0;
        end else begin
          if (w_tx_push[g]) r_tx_wp <= r_tx_wp + c_one;
          if (w_tx_go) begin
            r_tx_rp   <= r_tx_rp + c_one;
            r_tx_busy <= ~w_tx_head[c_fw];
          end
          case ({w_tx_inc, w_tx_dec})
            2'b10:   r_tx_pkts <= r_tx_pkts + c_one;
            2'b01:   r_tx_pkts <= r_tx_pkts - c_one;
            default: r_tx_pkts <= r_tx_pkts;
          endcase
          if (w_ovf_set[g])      r_ovf <= 1'b1;
          else if (w_ovf_clr[g]) r_ovf <= 1'b0;
        end
      end

      assign noc_out_flit[g*c_fw +: c_fw] = w_tx_head[c_fw-1:0];
      assign noc_out_last[g]              = w_tx_head[c_fw];
      assign noc_out_valid[g]             = w_tx_valid;

      // ---------------- RX ----------------
      assign w_rx_top   = r_rx_mem[r_rx_rp[c_aw-1:0]];
      assign w_rx_empty = (r_rx_wp == r_rx_rp);
      assign w_rx_full  = (r_rx_wp[c_aw] != r_rx_rp[c_aw]) &&
                          (r_rx_wp[c_aw-1:0] == r_rx_rp[c_aw-1:0]);
      assign w_rx_rdy   = r_rx_en & ~w_rx_full;
      assign w_rx_acc   = noc_in_valid[g] & w_rx_rdy;
      assign w_rx_inc   = w_rx_acc & noc_in_last[g];
      assign w_rx_dec   = w_rx_pop[g] & w_rx_top[c_fw];

      always_ff @(posedge clk) begin
        if (w_rx_acc) begin
          r_rx_mem[r_rx_wp[c_aw-1:0]] <= {noc_in_last[g], noc_in_flit[g*c_fw +: c_fw]};
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_rx_wp   <= '0;
          r_rx_rp   <= '0;
          r_rx_pkts <= '0;
        end else begin
          if (w_rx_acc)    r_rx_wp <= r_rx_wp + c_one;
          if (w_rx_pop[g]) r_rx_rp <= r_rx_rp + c_one;
          case ({w_rx_inc, w_rx_dec})
            2'b10:   r_rx_pkts <= r_rx_pkts + c_one;
            2'b01:   r_rx_pkts <= r_rx_pkts - c_one;
            default: r_rx_pkts <= r_rx_pkts;
          endcase
        end
      end

      assign noc_in_ready[g] = w_rx_rdy;

      assign w_tx_full_v[g]  = w_tx_full;
      assign w_rx_empty_v[g] = w_rx_empty;
      assign w_rx_avail_v[g] = (r_rx_pkts != '0);
      assign w_rx_head[g]    = w_rx_top[c_fw-1:0];
      assign w_status[g]     = {8'h00, 8'(SIZE - int'(w_tx_level)), 8'(r_rx_pkts),
                                4'h0, r_ovf, w_rx_empty, w_tx_full, (r_rx_pkts != '0)};
    end else begin : g_tie
      assign w_tx_full_v[g]  = 1'b0;
      assign w_rx_empty_v[g] = 1'b0;
      assign w_rx_avail_v[g] = 1'b0;
      assign w_rx_head[g]    = '0;
      assign w_status[g]     = '0;
    end
  end

  assign w_unused = ^{wb_adr_i[31:11], wb_adr_i[7:6], wb_adr_i[1:0], wb_dat_i,
                      w_tx_push, w_rx_pop, w_ovf_set, w_ovf_clr, w_ien_we};

endmodule
`default_nettype wire

// File: tb/tb_mpi_wb_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mpi_wb_mc                                                    |
// | Brief    : Directed, table-driven bench for mpi_wb_mc (2 channels).        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mpi_wb_mc;
  localparam int c_w = 32;
  localparam int c_n = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [c_n*c_w-1:0] noc_out_flit;
  logic [c_n-1:0]     noc_out_last;
  logic [c_n-1:0]     noc_out_valid;
  logic [c_n-1:0]     noc_out_ready;
  logic [c_n*c_w-1:0] noc_in_flit;
  logic [c_n-1:0]     noc_in_last;
  logic [c_n-1:0]     noc_in_valid;
  logic [c_n-1:0]     noc_in_ready;
  logic [31:0]        wb_adr_i;
  logic               wb_we_i;
  logic               wb_cyc_i;
  logic               wb_stb_i;
  logic [31:0]        wb_dat_i;
  logic [31:0]        wb_dat_o;
  logic               wb_ack_o;
  logic               wb_err_o;
  logic               irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mpi_wb_mc #(
    .NOC_FLIT_WIDTH(c_w),
    .SIZE          (16),
    .N             (c_n),
    .TX_STORE_FWD  (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .noc_out_flit (noc_out_flit),
    .noc_out_last (noc_out_last),
    .noc_out_valid(noc_out_valid),
    .noc_out_ready(noc_out_ready),
    .noc_in_flit  (noc_in_flit),
    .noc_in_last  (noc_in_last),
    .noc_in_valid (noc_in_valid),
    .noc_in_ready (noc_in_ready),
    .wb_adr_i     (wb_adr_i),
    .wb_we_i      (wb_we_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_stb_i     (wb_stb_i),
    .wb_dat_i     (wb_dat_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o),
    .wb_err_o     (wb_err_o),
    .irq          (irq)
  );

  typedef struct {
    logic        we;
    logic [2:0]  ch;
    logic [3:0]  rg;
    logic [31:0] wdat;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] ch, input logic [3:0] rg,
                              input logic [31:0] wdat, input logic ea, input logic ee,
                              input logic [31:0] ed);
    vec_t v;
    v.we = we; v.ch = ch; v.rg = rg; v.wdat = wdat;
    v.exp_ack = ea; v.exp_err = ee; v.exp_dat = ed;
    return v;
  endfunction

  function automatic logic [31:0] adr(input logic [2:0] ch, input logic [3:0] rg);
    return {21'd0, ch, 2'b00, rg, 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One classic cycle; returns the response seen in the cycle after the request edge.
  task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                         output logic ack, output logic err, output logic [31:0] rd);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d;
    ack = 1'b0; err = 1'b0; rd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o || wb_err_o) begin
        ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic run_table(input string tag);
    logic        a;
    logic        e;
    logic [31:0] d;
    foreach (vecs[i]) begin
      wb_xfer(vecs[i].we, adr(vecs[i].ch, vecs[i].rg), vecs[i].wdat, a, e, d);
      check($sformatf("%s[%0d] ack/err", tag, i), {30'd0, a, e},
            {30'd0, vecs[i].exp_ack, vecs[i].exp_err});
      check($sformatf("%s[%0d] dat", tag, i), d, vecs[i].exp_dat);
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        a;
    logic        e;
    logic [31:0] d;
    int          acks;
    logic [31:0] exp_fl [2];
    logic        exp_la [2];

    rst = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0;
    noc_out_ready = '0; noc_in_valid = '0; noc_in_last = '0; noc_in_flit = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst ack/err/irq", {29'd0, wb_ack_o, wb_err_o, irq}, 32'd0);
    check("rst dat", wb_dat_o, 32'd0);
    check("rst out_valid/in_ready", {28'd0, noc_out_valid, noc_in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready after release", {30'd0, noc_in_ready}, 32'h3);

    // Register map, decode and error cases
    vecs.push_back(mk(1'b0, 3'd0, 4'h2, 32'h0, 1'b1, 1'b0, 32'h00100004));
    vecs.push_back(mk(1'b0, 3'd1, 4'h2, 32'h0, 1'b1, 1'b0, 32'h00100004));
    vecs.push_back(mk(1'b0, 3'd0, 4'h3, 32'h0, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 3'd1, 4'h3, 32'h1, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 3'd1, 4'h3, 32'h0, 1'b1, 1'b0, 32'h1));
    vecs.push_back(mk(1'b0, 3'd0, 4'h1, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 3'd0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 3'd0, 4'h7, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 3'd1, 4'h7, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 3'd2, 4'h0, 32'h5, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 3'd2, 4'h2, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 3'd7, 4'h1, 32'h5, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 3'd0, 4'h2, 32'h0, 1'b1, 1'b0, 32'h00100004));
    vecs.push_back(mk(1'b0, 3'd1, 4'h2, 32'h0, 1'b1, 1'b0, 32'h00100004));
    vecs.push_back(mk(1'b0, 3'd1, 4'h3, 32'h0, 1'b1, 1'b0, 32'h1));
    run_table("regs");

    // Store-and-forward TX on ch0
    noc_out_ready = 2'b11;
    wb_xfer(1'b1, adr(3'd0, 4'h0), 32'hA1, a, e, d);
    check("sf A1 ack", {30'd0, a, e}, 32'h2);
    check("sf A1 gated", {31'd0, noc_out_valid[0]}, 32'd0);
    wb_xfer(1'b1, adr(3'd0, 4'h0), 32'hA2, a, e, d);
    check("sf A2 gated", {31'd0, noc_out_valid[0]}, 32'd0);
    wb_xfer(1'b0, adr(3'd0, 4'h2), 32'h0, a, e, d);
    check("sf status tx_free", d, 32'h000E0004);
    wb_xfer(1'b1, adr(3'd0, 4'h1), 32'hA3, a, e, d);
    check("sf LAST ack", {30'd0, a, e}, 32'h2);
    check("sf head A1", {noc_out_valid[0], noc_out_last[0], 30'd0} | noc_out_flit[31:0],
          32'h800000A1);
    exp_fl[0] = 32'hA2; exp_fl[1] = 32'hA3;
    exp_la[0] = 1'b0;   exp_la[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("sf stream %0d", k),
            {noc_out_valid[0], noc_out_last[0], 30'd0} | noc_out_flit[31:0],
            {1'b1, exp_la[k], 30'd0} | exp_fl[k]);
    end
    @(posedge clk); #1;
    check("sf drained", {31'd0, noc_out_valid[0]}, 32'd0);

    // TX overflow on ch0
    noc_out_ready = 2'b00;
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      wb_xfer(1'b1, adr(3'd0, 4'h0), 32'h100 + 32'(i), a, e, d);
      if (a && !e) acks++;
    end
    check("ovf 16 pushes acked", 32'(acks), 32'd16);
    check("ovf no packet released", {31'd0, noc_out_valid[0]}, 32'd0);
    vecs.push_back(mk(1'b1, 3'd0, 4'h0, 32'h117, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 3'd0, 4'h2, 32'h0, 1'b1, 1'b0, 32'h0000000E));
    vecs.push_back(mk(1'b1, 3'd0, 4'h2, 32'h8, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 3'd0, 4'h2, 32'h0, 1'b1, 1'b0, 32'h00000006));
    vecs.push_back(mk(1'b0, 3'd1, 4'h2, 32'h0, 1'b1, 1'b0, 32'h00100004));
    run_table("ovf");

    // 3-flit RX packet on ch1 with interrupt enabled
    @(negedge clk);
    noc_in_valid[1] = 1'b1; noc_in_last[1] = 1'b0; noc_in_flit[63:32] = 32'hDEAD00B1;
    @(negedge clk);
    noc_in_flit[63:32] = 32'hBEEF00B2;
    @(negedge clk);
    noc_in_flit[63:32] = 32'hCAFE00B3; noc_in_last[1] = 1'b1;
    @(posedge clk); #1;
    check("irq not yet", {31'd0, irq}, 32'd0);
    @(negedge clk);
    noc_in_valid[1] = 1'b0; noc_in_last[1] = 1'b0;
    @(posedge clk); #1;
    check("irq raised", {31'd0, irq}, 32'd1);
    vecs.push_back(mk(1'b0, 3'd1, 4'h2, 32'h0, 1'b1, 1'b0, 32'h00100101));
    vecs.push_back(mk(1'b0, 3'd1, 4'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD00B1));
    vecs.push_back(mk(1'b0, 3'd1, 4'h0, 32'h0, 1'b1, 1'b0, 32'hBEEF00B2));
    vecs.push_back(mk(1'b0, 3'd1, 4'h0, 32'h0, 1'b1, 1'b0, 32'hCAFE00B3));
    run_table("rx");
    check("irq held through last pop", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    check("irq dropped", {31'd0, irq}, 32'd0);
    wb_xfer(1'b0, adr(3'd1, 4'h0), 32'h0, a, e, d);
    check("rx 4th read err", {30'd0, a, e}, 32'h1);
    check("rx 4th read dat", d, 32'd0);

    // Fill ch0 RX while ch1 takes a 1-flit packet
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      noc_in_valid[0] = 1'b1; noc_in_last[0] = 1'b0; noc_in_flit[31:0] = 32'hC0 + 32'(i);
      noc_in_valid[1] = (i == 0); noc_in_last[1] = (i == 0); noc_in_flit[63:32] = 32'hD1;
      @(posedge clk);
    end
    #1;
    check("rx fill ready", {30'd0, noc_in_ready}, 32'h2);
    check("rx fill irq ch1", {31'd0, irq}, 32'd1);

    // Async reset in the middle of an ack and an RX offer
    @(negedge clk);
    noc_in_valid[1] = 1'b0; noc_in_last[1] = 1'b0; noc_in_flit[31:0] = 32'hEE;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr(3'd0, 4'h0);
    @(posedge clk); #1;
    check("pre-rst ack", {30'd0, wb_ack_o, wb_err_o}, 32'h2);
    check("pre-rst dat", wb_dat_o, 32'hC0);
    rst = 1'b0;
    #1;
    check("async rst ack/err/irq", {29'd0, wb_ack_o, wb_err_o, irq}, 32'd0);
    check("async rst dat", wb_dat_o, 32'd0);
    check("async rst valid/ready", {28'd0, noc_out_valid, noc_in_ready}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; noc_in_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready after 2nd release", {30'd0, noc_in_ready}, 32'h3);

    vecs.push_back(mk(1'b0, 3'd0, 4'h2, 32'h0, 1'b1, 1'b0, 32'h00100004));
    vecs.push_back(mk(1'b0, 3'd1, 4'h2, 32'h0, 1'b1, 1'b0, 32'h00100004));
    vecs.push_back(mk(1'b0, 3'd1, 4'h3, 32'h0, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 3'd0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 3'd1, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0));
    run_table("post-rst");

    noc_out_ready = 2'b11;
    wb_xfer(1'b1, adr(3'd0, 4'h1), 32'h55, a, e, d);
    check("post-rst tx head", {noc_out_valid[0], noc_out_last[0], 30'd0} | noc_out_flit[31:0],
          32'hC0000055);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
